// File: rtl/store_pkg.sv
// Shared types and op encodings for the M-stage store path.
package store_pkg;

   localparam int ST_ADDR_W = 32;

   localparam logic [1:0] ST_WORD = 2'b00;
   localparam logic [1:0] ST_HALF = 2'b01;
   localparam logic [1:0] ST_BYTE = 2'b10;
   localparam logic [1:0] ST_RSVD = 2'b11;

   // One queued bus write: word address, lane-aligned data and byte enables.
   typedef struct packed {
      logic [ST_ADDR_W-1:2] addr;
      logic [31:0]          wdata;
      logic [3:0]           byteen;
   } st_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store request port (pipeline side) and data-bus write port of the store buffer.
interface store_buffer_if #(
   parameter int ADDR_W = 32
);
   logic              st_valid;
   logic [1:0]        st_op;
   logic [ADDR_W-1:0] st_addr;
   logic [31:0]       st_data;
   logic              st_ready;

   logic              m_data_valid;
   logic              m_data_ready;
   logic [ADDR_W-1:0] m_data_addr;
   logic [31:0]       m_data_wdata;
   logic [3:0]        m_data_byteen;

   logic              empty;
   logic              exc_ades;

   modport master (
      output st_valid, st_op, st_addr, st_data, m_data_ready,
      input  st_ready, m_data_valid, m_data_addr, m_data_wdata, m_data_byteen,
             empty, exc_ades
   );

   modport slave (
      input  st_valid, st_op, st_addr, st_data, m_data_ready,
      output st_ready, m_data_valid, m_data_addr, m_data_wdata, m_data_byteen,
             empty, exc_ades
   );
endinterface

// File: rtl/store_align.sv
// Combinational sw/sh/sb lane alignment: byte enables, shifted write data, misalignment flag.
module store_align
   import store_pkg::*;
(
   input  logic [1:0]  op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] data_i,
   output logic [3:0]  byteen_o,
   output logic [31:0] wdata_o,
   output logic        misalign_o
);

   always_comb begin
      byteen_o   = 4'b0000;
      wdata_o    = 32'h0;
      misalign_o = 1'b0;
      unique case (op_i)
         ST_WORD: begin
            byteen_o   = 4'b1111;
            wdata_o    = data_i;
            misalign_o = (addr_lo_i != 2'b00);
         end
         ST_HALF: begin
            // Lane choice uses addr[1] only; addr[0] just flags misalignment.
            if (addr_lo_i[1]) begin
               byteen_o = 4'b1100;
               wdata_o  = {data_i[15:0], 16'h0};
            end else begin
               byteen_o = 4'b0011;
               wdata_o  = {16'h0, data_i[15:0]};
            end
            misalign_o = addr_lo_i[0];
         end
         ST_BYTE: begin
            byteen_o = 4'b0001 << addr_lo_i;
            wdata_o  = {24'h0, data_i[7:0]} << {addr_lo_i, 3'b000};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO feeding the data bus; accepted store is visible on the bus one cycle later, bus outputs held while ready=0.
// st_ready drops when full (no same-cycle pop-then-push); STORE_ALIGN_CHECK_EN rejects misaligned/reserved stores with exc_ades.
module store_buffer
   import store_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = ST_ADDR_W
) (
   input logic           clk,
   input logic           reset,
   store_buffer_if.slave bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

`ifdef STORE_ALIGN_CHECK_EN
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif

   logic [3:0]  al_byteen;
   logic [31:0] al_wdata;
   logic        al_misalign;

   store_align u_align (
      .op_i       (bus.st_op),
      .addr_lo_i  (bus.st_addr[1:0]),
      .data_i     (bus.st_data),
      .byteen_o   (al_byteen),
      .wdata_o    (al_wdata),
      .misalign_o (al_misalign)
   );

   st_entry_t        mem_q [DEPTH];
   st_entry_t        head;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic full, not_empty, accept, reject, push, pop;

   assign full      = (cnt_q == CNT_FULL);
   assign not_empty = (cnt_q != '0);
   assign accept    = bus.st_valid && !full;
   // Reserved ops are consumed as no-ops; rejection only exists with the check enabled.
   assign reject    = ALIGN_CHECK && (al_misalign || (bus.st_op == ST_RSVD));
   assign push      = accept && (bus.st_op != ST_RSVD) && !reject;
   assign pop       = not_empty && bus.m_data_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: outputs are masked whenever the count is zero.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{addr:   bus.st_addr[ADDR_W-1:2],
                              wdata:  al_wdata,
                              byteen: al_byteen};
      end
   end

   assign head              = mem_q[rd_ptr_q];
   assign bus.st_ready      = !full;
   assign bus.empty         = !not_empty;
   assign bus.m_data_valid  = not_empty;
   assign bus.m_data_addr   = not_empty ? {head.addr, 2'b00} : '0;
   assign bus.m_data_wdata  = not_empty ? head.wdata : 32'h0;
   assign bus.m_data_byteen = not_empty ? head.byteen : 4'b0000;

`ifdef STORE_ALIGN_CHECK_EN
   logic exc_q;

   always_ff @(posedge clk) begin
      if (reset) exc_q <= 1'b0;
      else       exc_q <= accept && reject;
   end

   assign bus.exc_ades = exc_q;
`else
   assign bus.exc_ades = 1'b0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer with a queue-based reference model and directed literal checks.
module tb_store_buffer;

   localparam int DEPTH = 2;

`ifdef STORE_ALIGN_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   bit   chk_en = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   store_buffer_if #(.ADDR_W(32)) sb_if ();

   store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sb_if)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } ent_t;

   ent_t q[$];
   bit   m_exc = 1'b0;

   // Reference: bytes of the operand laid into consecutive lanes from the start lane.
   always @(posedge clk) begin
      bit   acc, pop, mis;
      int   sz, start, lane;
      ent_t e;
      if (reset) begin
         q.delete();
         m_exc = 1'b0;
      end else begin
         acc   = sb_if.st_valid && (q.size() < DEPTH);
         pop   = (q.size() > 0) && sb_if.m_data_ready;
         m_exc = 1'b0;
         if (pop) void'(q.pop_front());
         if (acc) begin
            sz    = (sb_if.st_op == 2'd0) ? 4 : (sb_if.st_op == 2'd1) ? 2 : 1;
            start = (sb_if.st_op == 2'd0) ? 0 :
                    (sb_if.st_op == 2'd1) ? ((sb_if.st_addr % 4) >= 2 ? 2 : 0) :
                    int'(sb_if.st_addr % 4);
            mis   = CHECK && (((sb_if.st_op == 2'd0) && (sb_if.st_addr % 4 != 0)) ||
                              ((sb_if.st_op == 2'd1) && (sb_if.st_addr % 2 != 0)));
            if (sb_if.st_op == 2'd3) begin
               m_exc = CHECK;
            end else if (mis) begin
               m_exc = 1'b1;
            end else begin
               e.addr  = sb_if.st_addr - (sb_if.st_addr % 4);
               e.wdata = 32'h0;
               e.be    = 4'h0;
               for (int i = 0; i < sz; i++) begin
                  lane = start + i;
                  e.be[lane] = 1'b1;
                  e.wdata[lane*8 +: 8] = sb_if.st_data[i*8 +: 8];
               end
               q.push_back(e);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("empty",    32'(sb_if.empty),        32'(q.size() == 0));
         check("valid",    32'(sb_if.m_data_valid), 32'(q.size() != 0));
         check("st_ready", 32'(sb_if.st_ready),     32'(q.size() < DEPTH));
         check("exc_ades", 32'(sb_if.exc_ades),     32'(m_exc));
         if (q.size() != 0) begin
            check("addr",   sb_if.m_data_addr,          q[0].addr);
            check("wdata",  sb_if.m_data_wdata,         q[0].wdata);
            check("byteen", 32'(sb_if.m_data_byteen),   32'(q[0].be));
         end else begin
            check("idle_addr",   sb_if.m_data_addr,        32'h0);
            check("idle_wdata",  sb_if.m_data_wdata,       32'h0);
            check("idle_byteen", 32'(sb_if.m_data_byteen), 32'h0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic set_st(input bit v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
      sb_if.st_valid = v;
      sb_if.st_op    = op;
      sb_if.st_addr  = a;
      sb_if.st_data  = d;
   endtask

   initial begin
      set_st(0, 2'd0, 32'h0, 32'h0);
      sb_if.m_data_ready = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      chk_en = 1'b1;
      check("rst_empty",  32'(sb_if.empty),         32'h1);
      check("rst_ready",  32'(sb_if.st_ready),      32'h1);
      check("rst_valid",  32'(sb_if.m_data_valid),  32'h0);
      check("rst_byteen", 32'(sb_if.m_data_byteen), 32'h0);
      check("rst_addr",   sb_if.m_data_addr,        32'h0);
      check("rst_exc",    32'(sb_if.exc_ades),      32'h0);
      reset = 1'b0;

      // sw aligned
      sb_if.m_data_ready = 1'b1;
      set_st(1, 2'd0, 32'h0000_1004, 32'hDEAD_BEEF);
      tick();
      set_st(0, 2'd0, 32'h0, 32'h0);
      check("sw_valid",  32'(sb_if.m_data_valid),  32'h1);
      check("sw_addr",   sb_if.m_data_addr,        32'h0000_1004);
      check("sw_byteen", 32'(sb_if.m_data_byteen), 32'hF);
      check("sw_wdata",  sb_if.m_data_wdata,       32'hDEAD_BEEF);
      tick();
      check("sw_drained", 32'(sb_if.empty), 32'h1);

      // sh upper half, sb lane 1
      set_st(1, 2'd1, 32'h0000_1002, 32'h1234_ABCD);
      tick();
      set_st(0, 2'd0, 32'h0, 32'h0);
      check("sh_byteen", 32'(sb_if.m_data_byteen), 32'hC);
      check("sh_wdata",  sb_if.m_data_wdata,       32'hABCD_0000);
      tick();
      set_st(1, 2'd2, 32'h0000_1001, 32'h0000_00FF);
      tick();
      set_st(0, 2'd0, 32'h0, 32'h0);
      check("sb_byteen", 32'(sb_if.m_data_byteen), 32'h2);
      check("sb_wdata",  sb_if.m_data_wdata,       32'h0000_FF00);
      tick();

      // back-pressure: third store waits for the first pop
      sb_if.m_data_ready = 1'b0;
      set_st(1, 2'd0, 32'h0000_2000, 32'h1111_1111);
      tick();
      set_st(1, 2'd0, 32'h0000_2004, 32'h2222_2222);
      tick();
      set_st(1, 2'd0, 32'h0000_2008, 32'h3333_3333);
      check("bp_full_ready", 32'(sb_if.st_ready), 32'h0);
      check("bp_head",       sb_if.m_data_addr,   32'h0000_2000);
      tick();
      check("bp_hold_ready", 32'(sb_if.st_ready), 32'h0);
      check("bp_hold_head",  sb_if.m_data_wdata,  32'h1111_1111);
      sb_if.m_data_ready = 1'b1;
      tick();
      check("bp_rise_ready", 32'(sb_if.st_ready), 32'h1);
      check("bp_second",     sb_if.m_data_addr,   32'h0000_2004);
      tick();
      set_st(0, 2'd0, 32'h0, 32'h0);
      check("bp_third",       sb_if.m_data_addr,    32'h0000_2008);
      check("bp_third_valid", 32'(sb_if.m_data_valid), 32'h1);
      tick();
      check("bp_done", 32'(sb_if.empty), 32'h1);

      // reset discards queued stores
      sb_if.m_data_ready = 1'b0;
      set_st(1, 2'd2, 32'h0000_3003, 32'h0000_00AA);
      tick();
      set_st(1, 2'd1, 32'h0000_3000, 32'h0000_BBBB);
      tick();
      set_st(0, 2'd0, 32'h0, 32'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rq_valid",  32'(sb_if.m_data_valid),  32'h0);
      check("rq_empty",  32'(sb_if.empty),         32'h1);
      check("rq_byteen", 32'(sb_if.m_data_byteen), 32'h0);
      sb_if.m_data_ready = 1'b1;
      tick();
      check("rq_no_write", 32'(sb_if.m_data_valid), 32'h0);

      // misaligned word
      set_st(1, 2'd0, 32'h0000_1002, 32'hCAFE_F00D);
      tick();
      set_st(0, 2'd0, 32'h0, 32'h0);
`ifdef STORE_ALIGN_CHECK_EN
      check("mis_exc",   32'(sb_if.exc_ades),     32'h1);
      check("mis_valid", 32'(sb_if.m_data_valid), 32'h0);
      tick();
      check("mis_exc_pulse", 32'(sb_if.exc_ades), 32'h0);
`else
      check("mis_byteen", 32'(sb_if.m_data_byteen), 32'hF);
      check("mis_addr",   sb_if.m_data_addr,        32'h0000_1000);
      check("mis_exc",    32'(sb_if.exc_ades),      32'h0);
      tick();
`endif

      // randomized traffic with occasional reset
      for (int c = 0; c < 3000; c++) begin
         set_st(($urandom % 4) != 0, 2'($urandom % 4), $urandom, $urandom);
         sb_if.m_data_ready = (c % 64 < 20) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
         reset = (($urandom % 200) == 0);
         tick();
      end
      reset = 1'b0;
      set_st(0, 2'd0, 32'h0, 32'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
